// File: rtl/dram_cache_tag_compare.sv
// DRAM-cache tag check stage: pairs a returned line with its request, decides hit/miss and routes it.
// Optional hit/miss counters are enabled by defining TAG_COMPARE_STATS_EN.
module dram_cache_tag_compare #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int ID_W     = 16,
    parameter int TID_W    = 10,
    parameter int TAG_S    = 64,
    parameter int TAG_W    = 16,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 38
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_W-1:0]            rid_i,
    input  logic [TAG_S+DATA_W-1:0]    rdata_i,
    input  logic                       rvalid_i,
    output logic                       rready_o,
    input  logic                       tag_fifo_aempty_i,
    output logic                       tag_fifo_rden_o,
    input  logic [TID_W+ADDR_W:0]      tag_fifo_data_i,
    input  logic                       wbuffer_aempty_i,
    output logic                       wbuffer_rden_o,
    input  logic [DATA_W-1:0]          wbuffer_data_i,
    input  logic                       rob_afull_i,
    output logic                       rob_wren_o,
    output logic [TID_W+DATA_W-1:0]    rob_data_o,
    input  logic                       ar_fifo_afull_i,
    output logic                       ar_fifo_wren_o,
    output logic [TID_W+ADDR_W-1:0]    ar_fifo_data_o,
    input  logic                       aw_fifo_afull_i,
    output logic                       aw_fifo_wren_o,
    output logic [ADDR_W-1:0]          aw_fifo_data_o,
    input  logic                       w_fifo_afull_i,
    output logic                       w_fifo_wren_o,
    output logic [ADDR_W+DATA_W-1:0]   w_fifo_data_o,
    input  logic                       fill_ready_i,
    output logic                       fill_valid_o,
    output logic [ADDR_W+DATA_W-1:0]   fill_data_o
`ifdef TAG_COMPARE_STATS_EN
    ,
    output logic [31:0]                hit_cnt_o,
    output logic [31:0]                miss_cnt_o
`endif
);

    typedef enum logic [2:0] {IDLE, DEC, RHIT, RMISS, WHIT, WMISS} state_t;

    state_t state_q, state_n;

    logic [TAG_S-1:0]  tag_word_q;
    logic [DATA_W-1:0] line_q;
    logic              rw_q;
    logic [TID_W-1:0]  tid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              latch;

    logic              stored_valid, stored_dirty, hit, dirty_victim, wb_room;
    logic [TAG_W-1:0]  stored_tag;
    logic [ADDR_W-1:0] victim_addr;

    logic                     rready_n, tag_rden_n, rob_wren_n, ar_wren_n;
    logic                     aw_wren_n, w_wren_n, wb_rden_n, fill_valid_n;
    logic [TID_W+DATA_W-1:0]  rob_data_n;
    logic [TID_W+ADDR_W-1:0]  ar_data_n;
    logic [ADDR_W-1:0]        aw_data_n;
    logic [ADDR_W+DATA_W-1:0] w_data_n, fill_data_n;

    assign stored_valid = tag_word_q[TAG_S-1];
    assign stored_dirty = tag_word_q[TAG_S-2];
    assign stored_tag   = tag_word_q[TAG_S-3 -: TAG_W];
    assign hit          = stored_valid && (stored_tag == addr_q[ADDR_W-1 -: TAG_W]);
    assign dirty_victim = stored_valid && stored_dirty;
    assign victim_addr  = {stored_tag, addr_q[OFFSET_W +: INDEX_W], {OFFSET_W{1'b0}}};
    assign wb_room      = !aw_fifo_afull_i && !w_fifo_afull_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n      = state_q;
        latch        = 1'b0;
        rready_n     = 1'b0;
        tag_rden_n   = 1'b0;
        rob_wren_n   = 1'b0;
        ar_wren_n    = 1'b0;
        aw_wren_n    = 1'b0;
        w_wren_n     = 1'b0;
        wb_rden_n    = 1'b0;
        fill_valid_n = 1'b0;
        rob_data_n   = rob_data_o;
        ar_data_n    = ar_fifo_data_o;
        aw_data_n    = aw_fifo_data_o;
        w_data_n     = w_fifo_data_o;
        fill_data_n  = fill_data_o;
        case (state_q)
            IDLE: if (rvalid_i && !tag_fifo_aempty_i) begin
                latch      = 1'b1;
                rready_n   = 1'b1;
                tag_rden_n = 1'b1;
                state_n    = DEC;
            end
            DEC: begin
                if (rw_q) state_n = hit ? WHIT : WMISS;
                else      state_n = hit ? RHIT : RMISS;
            end
            RHIT: if (!rob_afull_i) begin
                rob_wren_n = 1'b1;
                rob_data_n = {tid_q, line_q};
                state_n    = IDLE;
            end
            RMISS: if (!ar_fifo_afull_i && (!dirty_victim || wb_room)) begin
                ar_wren_n = 1'b1;
                ar_data_n = {tid_q, addr_q};
                state_n   = IDLE;
            end
            WHIT, WMISS: if (!wbuffer_aempty_i && fill_ready_i &&
                             (state_q == WHIT || !dirty_victim || wb_room)) begin
                wb_rden_n    = 1'b1;
                fill_valid_n = 1'b1;
                fill_data_n  = {addr_q, wbuffer_data_i};
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A dirty victim is written back alongside the miss that evicts it.
        if ((ar_wren_n || (fill_valid_n && state_q == WMISS)) && dirty_victim) begin
            aw_wren_n = 1'b1;
            aw_data_n = victim_addr;
            w_wren_n  = 1'b1;
            w_data_n  = {victim_addr, line_q};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tag_word_q     <= '0;
            line_q         <= '0;
            rw_q           <= 1'b0;
            tid_q          <= '0;
            addr_q         <= '0;
            rready_o       <= 1'b0;
            tag_fifo_rden_o <= 1'b0;
            rob_wren_o     <= 1'b0;
            ar_fifo_wren_o <= 1'b0;
            aw_fifo_wren_o <= 1'b0;
            w_fifo_wren_o  <= 1'b0;
            wbuffer_rden_o <= 1'b0;
            fill_valid_o   <= 1'b0;
            rob_data_o     <= '0;
            ar_fifo_data_o <= '0;
            aw_fifo_data_o <= '0;
            w_fifo_data_o  <= '0;
            fill_data_o    <= '0;
        end else begin
            state_q        <= state_n;
            if (latch) begin
                {tag_word_q, line_q}  <= rdata_i;
                {rw_q, tid_q, addr_q} <= tag_fifo_data_i;
            end
            rready_o       <= rready_n;
            tag_fifo_rden_o <= tag_rden_n;
            rob_wren_o     <= rob_wren_n;
            ar_fifo_wren_o <= ar_wren_n;
            aw_fifo_wren_o <= aw_wren_n;
            w_fifo_wren_o  <= w_wren_n;
            wbuffer_rden_o <= wb_rden_n;
            fill_valid_o   <= fill_valid_n;
            rob_data_o     <= rob_data_n;
            ar_fifo_data_o <= ar_data_n;
            aw_fifo_data_o <= aw_data_n;
            w_fifo_data_o  <= w_data_n;
            fill_data_o    <= fill_data_n;
        end
    end

`ifdef TAG_COMPARE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == DEC) begin
            if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
            else     miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_cache_tag_compare.sv
// Bench for dram_cache_tag_compare: directed cases plus randomized transactions with random
// backpressure, checked against a transaction-level model of the hit/miss routing rules.
module tb_dram_cache_tag_compare;

    localparam int ADDR_W = 64, DATA_W = 512, ID_W = 16, TID_W = 10, TAG_S = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [ID_W-1:0]           rid_i;
    logic [TAG_S+DATA_W-1:0]   rdata_i;
    logic                      rvalid_i, rready_o;
    logic                      tag_fifo_aempty_i, tag_fifo_rden_o;
    logic [TID_W+ADDR_W:0]     tag_fifo_data_i;
    logic                      wbuffer_aempty_i, wbuffer_rden_o;
    logic [DATA_W-1:0]         wbuffer_data_i;
    logic                      rob_afull_i, rob_wren_o;
    logic [TID_W+DATA_W-1:0]   rob_data_o;
    logic                      ar_fifo_afull_i, ar_fifo_wren_o;
    logic [TID_W+ADDR_W-1:0]   ar_fifo_data_o;
    logic                      aw_fifo_afull_i, aw_fifo_wren_o;
    logic [ADDR_W-1:0]         aw_fifo_data_o;
    logic                      w_fifo_afull_i, w_fifo_wren_o;
    logic [ADDR_W+DATA_W-1:0]  w_fifo_data_o;
    logic                      fill_ready_i, fill_valid_o;
    logic [ADDR_W+DATA_W-1:0]  fill_data_o;
`ifdef TAG_COMPARE_STATS_EN
    logic [31:0]               hit_cnt_o, miss_cnt_o;
`endif

    dram_cache_tag_compare dut (
        .clk(clk), .rst(rst), .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o), .tag_fifo_aempty_i(tag_fifo_aempty_i),
        .tag_fifo_rden_o(tag_fifo_rden_o), .tag_fifo_data_i(tag_fifo_data_i),
        .wbuffer_aempty_i(wbuffer_aempty_i), .wbuffer_rden_o(wbuffer_rden_o),
        .wbuffer_data_i(wbuffer_data_i), .rob_afull_i(rob_afull_i), .rob_wren_o(rob_wren_o),
        .rob_data_o(rob_data_o), .ar_fifo_afull_i(ar_fifo_afull_i),
        .ar_fifo_wren_o(ar_fifo_wren_o), .ar_fifo_data_o(ar_fifo_data_o),
        .aw_fifo_afull_i(aw_fifo_afull_i), .aw_fifo_wren_o(aw_fifo_wren_o),
        .aw_fifo_data_o(aw_fifo_data_o), .w_fifo_afull_i(w_fifo_afull_i),
        .w_fifo_wren_o(w_fifo_wren_o), .w_fifo_data_o(w_fifo_data_o),
        .fill_ready_i(fill_ready_i), .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o)
`ifdef TAG_COMPARE_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int main_cyc;

    task automatic check(input string tag, input logic [599:0] obs, input logic [599:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TAG_S-1:0] mk_tw(input logic v, input logic d, input logic [15:0] t);
        return {v, d, t, 46'b0};
    endfunction

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] l;
        for (int i = 0; i < DATA_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic idle_inputs();
        rid_i = '0; rvalid_i = 1'b0; tag_fifo_aempty_i = 1'b1;
        wbuffer_aempty_i = 1'b0; rob_afull_i = 1'b0; ar_fifo_afull_i = 1'b0;
        aw_fifo_afull_i = 1'b0; w_fifo_afull_i = 1'b0; fill_ready_i = 1'b1;
    endtask

    // One request end to end. rob_hold > 0 keeps rob_afull_i high for that many sample slots.
    task automatic run_txn(input string name, input logic rw, input logic [TID_W-1:0] tid,
                           input logic [ADDR_W-1:0] addr, input logic [TAG_S-1:0] tw,
                           input logic [DATA_W-1:0] line, input logic [DATA_W-1:0] wbuf,
                           input bit rand_bp, input int rob_hold);
        logic hit, dirty, s_rob, s_ar, s_aw, s_w, s_wbe, s_fr;
        logic [ADDR_W-1:0] victim;
        logic [599:0] rob_d, ar_d, aw_d, w_d, fill_d;
        int n_rr, n_tr, n_rob, n_ar, n_aw, n_w, n_wb, n_fill, viol, done, t_aw, t_w;
        hit    = tw[63] && (tw[61:46] == addr[63:48]);
        dirty  = tw[63] && tw[62];
        victim = {tw[61:46], addr[47:38], 38'b0};
        if (hit) exp_hits++; else exp_misses++;
        {n_rr, n_tr, n_rob, n_ar, n_aw, n_w, n_wb, n_fill, viol} = '0;
        done = -1; t_aw = -1; t_w = -1; main_cyc = -1;
        {rob_d, ar_d, aw_d, w_d, fill_d} = '0;

        @(negedge clk);
        rdata_i = {tw, line}; tag_fifo_data_i = {rw, tid, addr}; wbuffer_data_i = wbuf;
        rid_i = 16'(($urandom));
        rvalid_i = 1'b1; tag_fifo_aempty_i = 1'b0; rob_afull_i = (rob_hold > 0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            s_rob = rob_afull_i; s_ar = ar_fifo_afull_i; s_aw = aw_fifo_afull_i;
            s_w = w_fifo_afull_i; s_wbe = wbuffer_aempty_i; s_fr = fill_ready_i;
            if (rready_o) begin n_rr++; rvalid_i = 1'b0; tag_fifo_aempty_i = 1'b1; end
            if (tag_fifo_rden_o) n_tr++;
            if (rob_wren_o) begin
                n_rob++; rob_d = 600'(rob_data_o); main_cyc = c;
                if (s_rob) viol++;
            end
            if (ar_fifo_wren_o) begin
                n_ar++; ar_d = 600'(ar_fifo_data_o); main_cyc = c;
                if (s_ar || (dirty && (s_aw || s_w))) viol++;
            end
            if (aw_fifo_wren_o) begin n_aw++; aw_d = 600'(aw_fifo_data_o); t_aw = c; if (s_aw) viol++; end
            if (w_fifo_wren_o)  begin n_w++;  w_d  = 600'(w_fifo_data_o);  t_w  = c; if (s_w)  viol++; end
            if (wbuffer_rden_o) begin n_wb++; if (s_wbe || !s_fr) viol++; end
            if (fill_valid_o) begin
                n_fill++; fill_d = 600'(fill_data_o); main_cyc = c;
                if (s_wbe || !s_fr || (dirty && !hit && (s_aw || s_w))) viol++;
            end
            if (done < 0 && (rob_wren_o || ar_fifo_wren_o || fill_valid_o)) done = c;
            if (done >= 0 && c >= done + 4) break;
            if (rand_bp) begin
                rob_afull_i      = ($urandom % 3) == 0;
                ar_fifo_afull_i  = ($urandom % 3) == 0;
                aw_fifo_afull_i  = ($urandom % 3) == 0;
                w_fifo_afull_i   = ($urandom % 3) == 0;
                wbuffer_aempty_i = ($urandom % 3) == 0;
                fill_ready_i     = ($urandom % 3) != 0;
            end else begin
                rob_afull_i = (c + 1 < rob_hold);
            end
        end
        idle_inputs();

        check($sformatf("%s completed", name), done >= 0, 1'b1);
        check($sformatf("%s rready", name), n_rr, 1);
        check($sformatf("%s tag_rden", name), n_tr, 1);
        check($sformatf("%s rob_cnt", name), n_rob, (!rw && hit) ? 1 : 0);
        check($sformatf("%s ar_cnt", name), n_ar, (!rw && !hit) ? 1 : 0);
        check($sformatf("%s aw_cnt", name), n_aw, (!hit && dirty) ? 1 : 0);
        check($sformatf("%s w_cnt", name), n_w, (!hit && dirty) ? 1 : 0);
        check($sformatf("%s wbuf_cnt", name), n_wb, rw ? 1 : 0);
        check($sformatf("%s fill_cnt", name), n_fill, rw ? 1 : 0);
        check($sformatf("%s stall_viol", name), viol, 0);
        if (!rw && hit) check($sformatf("%s rob_data", name), rob_d, 600'({tid, line}));
        if (!rw && !hit) check($sformatf("%s ar_data", name), ar_d, 600'({tid, addr}));
        if (rw) check($sformatf("%s fill_data", name), fill_d, 600'({addr, wbuf}));
        if (!hit && dirty) begin
            check($sformatf("%s aw_data", name), aw_d, 600'(victim));
            check($sformatf("%s w_data", name), w_d, 600'({victim, line}));
            check($sformatf("%s wb_same_cycle", name), {t_aw, t_w}, {main_cyc, main_cyc});
        end
    endtask

    localparam logic [ADDR_W-1:0] A = 64'h0003_0040_0000_0000;
    localparam logic [DATA_W-1:0] LINE_F = 512'hF;

    initial begin
        int npulse;
        logic rw_r;
        logic [ADDR_W-1:0] ra;
        logic [15:0] st;

        idle_inputs();
        rdata_i = '0; tag_fifo_data_i = '0; wbuffer_data_i = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset pulses", {rready_o, tag_fifo_rden_o, rob_wren_o, ar_fifo_wren_o,
              aw_fifo_wren_o, w_fifo_wren_o, wbuffer_rden_o, fill_valid_o}, 8'h00);
        check("reset rob_data", 600'(rob_data_o), 600'd0);
        check("reset fill_data", 600'(fill_data_o), 600'd0);
        rst = 1'b0;

        run_txn("read_hit", 1'b0, 10'd1, A, mk_tw(1, 1, 16'd3), LINE_F, '0, 0, 0);
        check("read_hit latency", main_cyc, 2);
        run_txn("read_miss", 1'b0, 10'd2, A, mk_tw(1, 1, 16'd7), LINE_F, '0, 0, 0);
        run_txn("read_miss_clean", 1'b0, 10'd5, A, mk_tw(1, 0, 16'd7), LINE_F, '0, 0, 0);
        run_txn("read_invalid", 1'b0, 10'd6, A, mk_tw(0, 1, 16'd3), LINE_F, '0, 0, 0);
        run_txn("write_hit", 1'b1, 10'd3, A, mk_tw(1, 1, 16'd3), LINE_F, 512'hE, 0, 0);
        run_txn("write_miss", 1'b1, 10'd4, A, mk_tw(1, 1, 16'd7), LINE_F, 512'hD, 0, 0);
        run_txn("rob_bp", 1'b0, 10'd9, A, mk_tw(1, 0, 16'd3), LINE_F, '0, 0, 7);
        check("rob_bp release cycle", main_cyc, 7);

        for (int i = 0; i < 40; i++) begin
            rw_r = 1'($urandom);
            ra   = {$urandom, $urandom};
            st   = ($urandom % 2) ? ra[63:48] : 16'($urandom);
            run_txn($sformatf("rand%0d", i), rw_r, 10'($urandom), ra,
                    mk_tw(($urandom % 4) != 0, 1'($urandom), st), rand_line(), rand_line(), 1, 0);
        end

`ifdef TAG_COMPARE_STATS_EN
        check("hit_cnt", hit_cnt_o, 32'(exp_hits));
        check("miss_cnt", miss_cnt_o, 32'(exp_misses));
`endif

        // Reset while the request sits in DEC: everything clears and the request is lost.
        @(negedge clk);
        rdata_i = {mk_tw(1, 1, 16'd7), LINE_F}; tag_fifo_data_i = {1'b0, 10'd8, A};
        rvalid_i = 1'b1; tag_fifo_aempty_i = 1'b0;
        @(negedge clk);
        check("dec rready", rready_o, 1'b1);
        rst = 1'b1;
        rvalid_i = 1'b0; tag_fifo_aempty_i = 1'b1;
        #1;
        check("dec_rst pulses", {rready_o, tag_fifo_rden_o, rob_wren_o, ar_fifo_wren_o,
              aw_fifo_wren_o, w_fifo_wren_o, wbuffer_rden_o, fill_valid_o}, 8'h00);
        check("dec_rst rob_data", 600'(rob_data_o), 600'd0);
        check("dec_rst ar_data", 600'(ar_fifo_data_o), 600'd0);
        check("dec_rst aw_data", 600'(aw_fifo_data_o), 600'd0);
        check("dec_rst w_data", 600'(w_fifo_data_o), 600'd0);
        check("dec_rst fill_data", 600'(fill_data_o), 600'd0);
`ifdef TAG_COMPARE_STATS_EN
        check("dec_rst counters", {hit_cnt_o, miss_cnt_o}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        npulse = 0;
        repeat (12) begin
            @(negedge clk);
            npulse += int'(rready_o) + int'(tag_fifo_rden_o) + int'(rob_wren_o) +
                      int'(ar_fifo_wren_o) + int'(aw_fifo_wren_o) + int'(w_fifo_wren_o) +
                      int'(wbuffer_rden_o) + int'(fill_valid_o);
        end
        check("post_rst no pulses", npulse, 0);

        run_txn("post_rst read_hit", 1'b0, 10'd11, A, mk_tw(1, 0, 16'd3), LINE_F, '0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
